// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO with first-word fall-through, occupancy count and almost_full.
// Define STREAM_FIFO_PROTO_CHECK_EN to add the sticky input-side protocol checker on err.
module stream_fifo #(
   parameter int WIDTH    = 18,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    count,
   output logic             almost_full,
   output logic [1:0]       err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             push;
   logic             pop;

   // Every output is decoded from registered state only; nothing flows from in_* to out_*.
   assign in_ready    = (count_q != CW'(DEPTH));
   assign out_valid   = (count_q != '0);
   assign out_data    = out_valid ? mem[rd_ptr] : '0;
   assign almost_full = (count_q >= CW'(AF_LEVEL));
   assign count       = count_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage has no reset; out_data is masked by out_valid, so stale words are never visible.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

`ifdef STREAM_FIFO_PROTO_CHECK_EN
   logic             stalled_q;
   logic [WIDTH-1:0] held_q;
   logic [1:0]       err_q;
   logic             stall;

   assign stall = in_valid & ~in_ready;

   // A producer that stalls must hold both valid and data until the word is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stalled_q <= 1'b0;
         held_q    <= '0;
         err_q     <= 2'b00;
      end else begin
         stalled_q <= stall;
         if (stall)
            held_q <= in_data;
         if (stalled_q && !in_valid)
            err_q[0] <= 1'b1;
         if (stalled_q && in_valid && (in_data != held_q))
            err_q[1] <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 2'b00;
`endif

endmodule
